// File: rtl/iterative_muldiv_unit.sv
// Iterative signed/unsigned MUL/MUH/DIV/MOD, one shift-add/subtract step per clock.
// Latency DataWidth+2 cycles (1 for divide-by-zero); Start is ignored while Busy.
module iterative_muldiv_unit #(
  parameter int DataWidth  = 16,
  parameter bit SignedMode = 1'b1
) (
  input  logic                 Clock,
  input  logic                 Reset,
  input  logic                 Start,
  input  logic [1:0]           Op,
  input  logic [DataWidth-1:0] InDest,
  input  logic [DataWidth-1:0] InSrc,
  output logic                 Busy,
  output logic                 Done,
  output logic [DataWidth-1:0] OutDest,
  output logic                 OutZero,
  output logic                 OutNegative,
  output logic                 OutParity,
  output logic                 OutOverflow,
  output logic                 DivByZero
);

  localparam int W  = DataWidth;
  localparam int CW = $clog2(DataWidth);

  typedef enum logic [1:0] {IDLE, CALC, SIGN, DONE} state_t;

  state_t          state, state_nxt;
  logic [1:0]      op_q;
  logic [W-1:0]    src_mag;
  logic [2*W-1:0]  acc;
  logic [CW-1:0]   cnt;
  logic            res_neg, rem_neg;

  logic            accept, div_zero, last;
  logic            dest_sgn, src_sgn;
  logic [W-1:0]    dest_mag, src_mag_in;
  logic [W:0]      mul_sum, div_shift, div_diff;
  logic [2*W-1:0]  acc_step, prod_s;
  logic [W-1:0]    res;
  logic            ovf;

  assign accept     = ((state == IDLE) || (state == DONE)) && Start;
  assign div_zero   = Op[1] && (InSrc == '0);
  assign last       = (cnt == CW'(W-1));
  assign dest_sgn   = SignedMode && InDest[W-1];
  assign src_sgn    = SignedMode && InSrc[W-1];
  assign dest_mag   = dest_sgn ? -InDest : InDest;
  assign src_mag_in = src_sgn ? -InSrc : InSrc;

  // Both operations start from {0, |InDest|}: the low half is the multiplier
  // being consumed LSB-first, or the dividend being consumed MSB-first.
  assign mul_sum   = {1'b0, acc[2*W-1:W]} + (acc[0] ? {1'b0, src_mag} : '0);
  assign div_shift = {acc[2*W-1:W], acc[W-1]};
  assign div_diff  = div_shift - {1'b0, src_mag};

  always_comb begin
    acc_step = {mul_sum, acc[W-1:1]};
    if (op_q[1]) begin
      if (div_diff[W]) acc_step = {div_shift[W-1:0], acc[W-2:0], 1'b0};
      else             acc_step = {div_diff[W-1:0],  acc[W-2:0], 1'b1};
    end
  end

  assign prod_s = res_neg ? -acc : acc;

  always_comb begin
    res = '0;
    ovf = 1'b0;
    case (op_q)
      2'd0: begin
        res = prod_s[W-1:0];
        if (SignedMode) ovf = (prod_s[2*W-1:W-1] != {(W+1){prod_s[W-1]}});
        else            ovf = (prod_s[2*W-1:W] != '0);
      end
      2'd1: res = prod_s[2*W-1:W];
      2'd2: begin
        res = res_neg ? -acc[W-1:0] : acc[W-1:0];
        // A positive quotient of magnitude 2^(W-1) only arises from MIN / -1.
        ovf = SignedMode && !res_neg && acc[W-1];
      end
      default: res = rem_neg ? -acc[2*W-1:W] : acc[2*W-1:W];
    endcase
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (Start) state_nxt = div_zero ? DONE : CALC;
      CALC: if (last) state_nxt = SIGN;
      SIGN: state_nxt = DONE;
      DONE: begin
        state_nxt = IDLE;
        if (Start) state_nxt = div_zero ? DONE : CALC;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      op_q        <= '0;
      src_mag     <= '0;
      acc         <= '0;
      cnt         <= '0;
      res_neg     <= 1'b0;
      rem_neg     <= 1'b0;
      OutDest     <= '0;
      OutZero     <= 1'b0;
      OutNegative <= 1'b0;
      OutParity   <= 1'b0;
      OutOverflow <= 1'b0;
      DivByZero   <= 1'b0;
    end else if (accept) begin
      op_q        <= Op;
      src_mag     <= src_mag_in;
      acc         <= {{W{1'b0}}, dest_mag};
      cnt         <= '0;
      res_neg     <= dest_sgn ^ src_sgn;
      rem_neg     <= dest_sgn;
      OutDest     <= '0;
      OutNegative <= 1'b0;
      OutOverflow <= 1'b0;
      OutZero     <= div_zero;
      OutParity   <= div_zero;
      DivByZero   <= div_zero;
    end else if (state == CALC) begin
      acc <= acc_step;
      cnt <= last ? '0 : cnt + 1'b1;
    end else if (state == SIGN) begin
      OutDest     <= res;
      OutZero     <= (res == '0);
      OutNegative <= SignedMode && res[W-1];
      OutParity   <= ~^res;
      OutOverflow <= ovf;
    end
  end

  assign Busy = (state == CALC) || (state == SIGN);
  assign Done = (state == DONE);

endmodule

// File: tb/tb_iterative_muldiv_unit.sv
// Scoreboarded random/directed bench driving a signed and an unsigned unit in lockstep.
module tb_iterative_muldiv_unit;
  localparam int W = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [1:0]    op = '0;
  logic [W-1:0]  a = '0, b = '0;

  logic          busy_s, done_s, z_s, n_s, p_s, o_s, d_s;
  logic          busy_u, done_u, z_u, n_u, p_u, o_u, d_u;
  logic [W-1:0]  out_s, out_u;

  iterative_muldiv_unit #(.DataWidth(W), .SignedMode(1'b1)) u_dut_s (
    .Clock(clk), .Reset(rst), .Start(start), .Op(op), .InDest(a), .InSrc(b),
    .Busy(busy_s), .Done(done_s), .OutDest(out_s), .OutZero(z_s),
    .OutNegative(n_s), .OutParity(p_s), .OutOverflow(o_s), .DivByZero(d_s));

  iterative_muldiv_unit #(.DataWidth(W), .SignedMode(1'b0)) u_dut_u (
    .Clock(clk), .Reset(rst), .Start(start), .Op(op), .InDest(a), .InSrc(b),
    .Busy(busy_u), .Done(done_u), .OutDest(out_u), .OutZero(z_u),
    .OutNegative(n_u), .OutParity(p_u), .OutOverflow(o_u), .DivByZero(d_u));

  always #5 clk = ~clk;

  typedef struct packed {
    logic [W-1:0] res;
    logic z, n, p, o, d;
  } exp_t;

  exp_t q_s[$];
  exp_t q_u[$];
  int   n_vec = 0;
  int   n_err = 0;

  function automatic exp_t model(input bit sgn, input logic [1:0] o,
                                 input logic [W-1:0] x, input logic [W-1:0] y);
    longint sx, sy, r;
    exp_t   e;
    e  = '0;
    r  = 0;
    sx = sgn ? longint'($signed(x)) : longint'(x);
    sy = sgn ? longint'($signed(y)) : longint'(y);
    case (o)
      2'd0: begin
        r   = sx * sy;
        e.o = sgn ? (r < -32768 || r > 32767) : (r > 65535);
      end
      2'd1: r = (sx * sy) >>> 16;
      2'd2: if (sy == 0) e.d = 1'b1;
            else begin r = sx / sy; e.o = sgn && (r > 32767); end
      default: if (sy == 0) e.d = 1'b1;
               else r = sx % sy;
    endcase
    e.res = r[W-1:0];
    e.z   = (e.res == '0);
    e.n   = sgn && e.res[W-1];
    e.p   = ~^e.res;
    return e;
  endfunction

  task automatic chk(input string name, input longint act, input longint req);
    n_vec++;
    if (act != req) begin
      n_err++;
      $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (done_s) begin
        chk("sb_pending_s", q_s.size() > 0, 1);
        if (q_s.size() > 0) begin
          e = q_s.pop_front();
          chk("result_signed", {out_s, z_s, n_s, p_s, o_s, d_s}, e);
        end
      end
      if (done_u) begin
        chk("sb_pending_u", q_u.size() > 0, 1);
        if (q_u.size() > 0) begin
          e = q_u.pop_front();
          chk("result_unsigned", {out_u, z_u, n_u, p_u, o_u, d_u}, e);
        end
      end
    end
  end

  // Called at posedge+1; returns in the Done cycle so a following call is back-to-back.
  task automatic run_op(input logic [1:0] o, input logic [W-1:0] x,
                        input logic [W-1:0] y, input bit pulse_mid);
    exp_t es;
    int   n;
    bit   busy_seen;
    op = o; a = x; b = y; start = 1'b1;
    es = model(1'b1, o, x, y);
    q_s.push_back(es);
    q_u.push_back(model(1'b0, o, x, y));
    @(posedge clk); #1;
    start = 1'b0;
    n = 1;
    busy_seen = 1'b0;
    while (!done_s && n < 40) begin
      busy_seen |= busy_s;
      if (pulse_mid && n == 3) begin
        start = 1'b1; a = ~a; b = b + 16'd3; op = op + 2'd1;
      end else start = 1'b0;
      @(posedge clk); #1;
      n++;
    end
    start = 1'b0;
    chk("latency", n, es.d ? 1 : W + 2);
    chk("busy_seen", busy_seen, !es.d);
  endtask

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 7))
      0: return 16'h0000;
      1: return 16'h0001;
      2: return 16'hFFFF;
      3: return 16'h8000;
      4: return 16'h7FFF;
      default: return W'($urandom);
    endcase
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, required finish before 1ms");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("reset_state_s", {busy_s, done_s, out_s, z_s, n_s, p_s, o_s, d_s}, 0);
    chk("reset_state_u", {busy_u, done_u, out_u, z_u, n_u, p_u, o_u, d_u}, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    run_op(2'd0, 16'd300, 16'hFFF9, 1'b0);
    chk("mul_300_m7", {out_s, n_s, o_s, z_s}, {16'hF7CC, 3'b100});
    run_op(2'd0, 16'h4000, 16'h0004, 1'b0);
    chk("mul_ovf", {out_s, z_s, o_s, p_s}, {16'h0000, 3'b111});
    run_op(2'd1, 16'h4000, 16'h0004, 1'b0);
    chk("muh_high", {out_s, p_s}, {16'h0001, 1'b0});
    run_op(2'd2, 16'hFFF9, 16'h0002, 1'b0);
    chk("div_m7_2", out_s, 16'hFFFD);
    chk("div_m7_2_unsigned", out_u, 16'h7FFC);
    run_op(2'd3, 16'hFFF9, 16'h0002, 1'b0);
    chk("mod_m7_2", {out_s, n_s}, {16'hFFFF, 1'b1});
    run_op(2'd2, 16'h1234, 16'h0000, 1'b0);
    chk("div_zero", {out_s, d_s, z_s, p_s, o_s}, {16'h0000, 4'b1110});
    run_op(2'd2, 16'h8000, 16'hFFFF, 1'b0);
    chk("div_min_m1", {out_s, o_s, n_s}, {16'h8000, 2'b11});

    run_op(2'd0, 16'd1234, 16'd5, 1'b1);
    chk("start_ignored_busy", out_s, 16'd6170);
    @(posedge clk); #1;
    chk("result_held_idle", out_s, 16'd6170);
    rst = 1'b1; #1;
    chk("reset_clears_held", {out_s, z_s, p_s, done_s}, 0);
    #2 rst = 1'b0;

    @(posedge clk); #1;
    op = 2'd0; a = 16'd77; b = 16'd9; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int n = 1; n < 6; n++) begin
      start = (n == 3);
      b = (n == 3) ? 16'd11 : b;
      @(posedge clk); #1;
    end
    start = 1'b0;
    chk("busy_before_reset", busy_s, 1);
    rst = 1'b1; #1;
    chk("async_reset_mid", {busy_s, done_s, out_s, busy_u, done_u, out_u}, 0);
    #2 rst = 1'b0;
    @(posedge clk); #1;
    run_op(2'd0, 16'd77, 16'd9, 1'b0);
    chk("after_reset_mul", out_s, 16'd693);

    for (int i = 0; i < 200; i++) begin
      if ($urandom_range(0, 2) != 0)
        repeat ($urandom_range(1, 2)) begin @(posedge clk); #1; end
      run_op(2'($urandom_range(0, 3)), pick(), pick(), 1'b0);
    end

    repeat (3) @(posedge clk);
    #1;
    chk("queues_drained", q_s.size() + q_u.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/iterative_muldiv_unit.md
Name: iterative_muldiv_unit

Overview:
- Multi-cycle signed/unsigned multiply/divide unit with a Start/Busy/Done handshake.
- Generalises the single-cycle MUL/MUH/DIV/MOD datapath to a parametrised width, using one shift-add or shift-subtract step per clock.
- Sits beside the ArithmeticLogicUnit. The control unit stalls on Busy and writes OutDest and the flags into the destination register and flag register when Done pulses.

Parameters:
- DataWidth, 16, operand/result width in bits (>=4).
- SignedMode, 1, 1 = two's-complement operands and results; 0 = unsigned.

Ports:
- Clock  input  1  rising-edge system clock.
- Reset  input  1  asynchronous, active-high; clears all state.
- Start  input  1  request; sampled only in IDLE or DONE.
- Op  input  2  0=MUL (low half), 1=MUH (high half), 2=DIV (quotient), 3=MOD (remainder).
- InDest  input  DataWidth  multiplicand / dividend.
- InSrc  input  DataWidth  multiplier / divisor.
- Busy  output  1  high in CALC and SIGN.
- Done  output  1  single-cycle pulse; results valid.
- OutDest  output  DataWidth  result; held until the next accepted Start.
- OutZero  output  1  OutDest == 0.
- OutNegative  output  1  OutDest MSB; forced 0 when SignedMode=0.
- OutParity  output  1  1 when the popcount of OutDest is even.
- OutOverflow  output  1  result not representable (see rules).
- DivByZero  output  1  DIV/MOD with InSrc == 0.

Behaviour:
- Reset (asynchronous, active-high): state = IDLE; all outputs 0; iteration counter 0. This applies immediately, including mid-operation. No partial result is ever output.
- States: IDLE, CALC, SIGN, DONE.
- Accept: Start=1 in IDLE or DONE latches Op and the operand magnitudes (absolute values when SignedMode=1), plus the result sign and remainder sign. OutDest and all flags clear to 0; counter = 0.
  - Next state is CALC.
  - Exception: DIV/MOD with InSrc == 0 goes to DONE with OutDest = 0, DivByZero = 1, OutZero = 1, OutParity = 1, OutOverflow = 0.
- Start while Busy=1 is ignored. It has no effect on the operation in flight.
- CALC, one step per cycle for DataWidth cycles; the counter increments and the state exits CALC when counter == DataWidth-1.
  - MUL/MUH: shift-add into a 2*DataWidth product register.
  - DIV/MOD: restoring shift-subtract producing quotient and remainder.
- SIGN (1 cycle): apply two's-complement negation to the product when the operand signs differ. Apply quotient sign = sign(InDest) XOR sign(InSrc) and remainder sign = sign(InDest), i.e. truncation toward zero. Register OutDest and all flags; next state DONE.
- DONE: Done = 1 for exactly this cycle; next state IDLE unless Start is accepted.
- Latency: Start sampled in cycle 0 gives Done in cycle DataWidth+2. The divide-by-zero path gives Done in cycle 1. Back-to-back Start in the DONE cycle is accepted with no bubble.
- Overflow rules:
  - MUL: set when the full product does not fit DataWidth bits (signed or unsigned per SignedMode).
  - DIV: set for most-negative / -1 (SignedMode=1); result wraps to most-negative.
  - MUH and MOD: always 0.
- Outputs are registered only. There is no combinational path from the inputs to any output.

Test Plan (DataWidth=16, SignedMode=1 unless stated):
- MUL, InDest=300, InSrc=0xFFF9 (-7) -> Done in cycle 18; OutDest=0xF7CC; OutNegative=1; OutOverflow=0; OutZero=0.
- MUL then MUH, InDest=0x4000, InSrc=0x0004 -> MUL: OutDest=0x0000, OutZero=1, OutOverflow=1, OutParity=1; MUH: OutDest=0x0001, OutParity=0.
- DIV then MOD, InDest=0xFFF9 (-7), InSrc=2 -> DIV: OutDest=0xFFFD (-3); MOD: OutDest=0xFFFF (-1), OutNegative=1. With SignedMode=0, DIV gives 0x7FFC.
- DIV, InDest=0x1234, InSrc=0 -> Done in cycle 1; OutDest=0; DivByZero=1; OutZero=1; Busy never asserted.
- DIV, InDest=0x8000, InSrc=0xFFFF -> OutDest=0x8000; OutOverflow=1; OutNegative=1.
- MUL started, Start re-pulsed with different operands in cycle 3, Reset pulsed in cycle 6 -> the cycle-3 Start is ignored; Busy, Done and OutDest drop to 0 asynchronously at Reset; a new Start after Reset completes normally with correct results.
